// File: rtl/alu_scheduler.sv
// Round-robin front-end for a shared combinational ALU: two requesters in,
// registered operands out, result captured after SETTLE cycles and returned tagged.
`timescale 1ns/1ps
module alu_scheduler #(
  parameter int WIDTH     = 16,
  parameter int RES_WIDTH = 32,
  parameter int SETTLE    = 1   // legal 1..15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             reqValid,
  output logic [1:0]             reqReady,
  input  logic [2*WIDTH-1:0]     reqA,
  input  logic [2*WIDTH-1:0]     reqB,
  input  logic [7:0]             reqCmd,
  output logic [WIDTH-1:0]       aluA,
  output logic [WIDTH-1:0]       aluB,
  output logic [3:0]             aluCmd,
  input  logic [RES_WIDTH-1:0]   aluResult,
  input  logic [1:0]             aluError,
  output logic                   rspValid,
  input  logic                   rspReady,
  output logic                   rspId,
  output logic [RES_WIDTH-1:0]   rspResult,
  output logic [1:0]             rspError,
  output logic                   busy,
  output logic [7:0]             errCount
);
  localparam int NREQ = 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                 state_q;
  logic                   last_q;
  logic                   owner_q;
  logic [3:0]             cnt_q;
  logic [WIDTH-1:0]       aluA_q, aluB_q;
  logic [3:0]             aluCmd_q;
  logic                   rspValid_q, rspId_q;
  logic [RES_WIDTH-1:0]   rspResult_q;
  logic [1:0]             rspError_q;
  logic [7:0]             errCount_q, errCount_d;

  logic [NREQ-1:0][WIDTH-1:0] opA, opB;
  logic [NREQ-1:0][3:0]       opCmd;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign opA[g]   = reqA[g*WIDTH +: WIDTH];
    assign opB[g]   = reqB[g*WIDTH +: WIDTH];
    assign opCmd[g] = reqCmd[g*4 +: 4];
  end

  logic win, legal, accept;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    win      = reqValid[1] & (~reqValid[0] | ~last_q);
    legal    = (opCmd[win] >= 4'd1) && (opCmd[win] <= 4'd5);
    accept   = rst_n && (state_q == S_IDLE) && reqValid[win];
    reqReady = '0;
    if (accept) reqReady[win] = 1'b1;
  end

  always_comb begin
    errCount_d = errCount_q;
    if ((rspError_q != 2'b00) && (errCount_q != 8'hFF)) errCount_d = errCount_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluCmd_q    <= '0;
      rspValid_q  <= 1'b0;
      rspId_q     <= 1'b0;
      rspResult_q <= '0;
      rspError_q  <= '0;
      errCount_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          last_q <= win;
          if (legal) begin
            aluA_q   <= opA[win];
            aluB_q   <= opB[win];
            aluCmd_q <= opCmd[win];
            owner_q  <= win;
            cnt_q    <= 4'(SETTLE);
            state_q  <= S_WAIT;
          end else begin
            // Illegal commands never reach the ALU; answer immediately.
            rspResult_q <= '0;
            rspError_q  <= 2'b11;
            rspId_q     <= win;
            rspValid_q  <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            rspResult_q <= aluResult;
            rspError_q  <= aluError;
            rspId_q     <= owner_q;
            rspValid_q  <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: if (rspReady) begin
          rspValid_q <= 1'b0;
          aluCmd_q   <= '0;
          errCount_q <= errCount_d;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign aluA      = aluA_q;
  assign aluB      = aluB_q;
  assign aluCmd    = aluCmd_q;
  assign rspValid  = rspValid_q;
  assign rspId     = rspId_q;
  assign rspResult = rspResult_q;
  assign rspError  = rspError_q;
  assign errCount  = errCount_q;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: instance 0 runs SETTLE=1, instance 1 runs SETTLE=4.
// A behavioural ALU feeds each DUT; a transaction model is compared every cycle.
`timescale 1ns/1ps
module tb_alu_scheduler;
  logic        clk;
  logic [1:0]  rst_n;
  logic [1:0]  reqValid  [2];
  logic [1:0]  reqReady  [2];
  logic [31:0] reqA      [2];
  logic [31:0] reqB      [2];
  logic [7:0]  reqCmd    [2];
  logic [15:0] aluA      [2];
  logic [15:0] aluB      [2];
  logic [3:0]  aluCmd    [2];
  logic [31:0] aluResult [2];
  logic [1:0]  aluError  [2];
  logic        rspValid  [2];
  logic        rspReady  [2];
  logic        rspId     [2];
  logic [31:0] rspResult [2];
  logic [1:0]  rspError  [2];
  logic        busy      [2];
  logic [7:0]  errCount  [2];
  bit   [1:0]  chk_en;
  int          checks   = 0;
  int          failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU: {error, result}; error = {divByZero, overflow}.
  function automatic logic [33:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] c);
    logic [31:0] r;
    logic [1:0]  e;
    r = '0;
    e = '0;
    case (c)
      4'd1: r = 32'(a) + 32'(b);
      4'd2: begin r = 32'(a) - 32'(b); e = (b > a) ? 2'b01 : 2'b00; end
      4'd3: r = 32'(a) * 32'(b);
      4'd4: if (b == 0) e = 2'b10; else r = 32'(a / b);
      4'd5: if (b == 0) e = 2'b10; else r = 32'(a % b);
      default: ;
    endcase
    return {e, r};
  endfunction

  function automatic bit pick(input logic [1:0] v, input bit last);
    return (v == 2'b11) ? !last : v[1];
  endfunction

  function automatic logic [1:0] exp_rr(input bit rn, input int ph, input logic [1:0] v,
                                        input bit last);
    if (!rn || ph != 0 || v == 2'b00) return 2'b00;
    return pick(v, last) ? 2'b10 : 2'b01;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int S = (g == 0) ? 1 : 4;

    alu_scheduler #(.WIDTH(16), .RES_WIDTH(32), .SETTLE(S)) u_dut (
      .clk(clk), .rst_n(rst_n[g]),
      .reqValid(reqValid[g]), .reqReady(reqReady[g]),
      .reqA(reqA[g]), .reqB(reqB[g]), .reqCmd(reqCmd[g]),
      .aluA(aluA[g]), .aluB(aluB[g]), .aluCmd(aluCmd[g]),
      .aluResult(aluResult[g]), .aluError(aluError[g]),
      .rspValid(rspValid[g]), .rspReady(rspReady[g]), .rspId(rspId[g]),
      .rspResult(rspResult[g]), .rspError(rspError[g]),
      .busy(busy[g]), .errCount(errCount[g])
    );

    assign {aluError[g], aluResult[g]} = alu_f(aluA[g], aluB[g], aluCmd[g]);

    // Model: phase 0 idle, 1 operation in flight, 2 response outstanding.
    int          m_ph, m_rem, m_ec;
    bit          m_last, m_pid, m_rv, m_rid;
    logic [15:0] m_a, m_b;
    logic [3:0]  m_cmd;
    logic [33:0] m_pend;
    logic [31:0] m_res;
    logic [1:0]  m_err;
    bit          p;
    logic [15:0] pa, pb;
    logic [3:0]  pc;
    assign p  = pick(reqValid[g], m_last);
    assign pa = p ? reqA[g][31:16] : reqA[g][15:0];
    assign pb = p ? reqB[g][31:16] : reqB[g][15:0];
    assign pc = p ? reqCmd[g][7:4] : reqCmd[g][3:0];

    always @(posedge clk) begin
      if (!rst_n[g]) begin
        m_ph <= 0; m_rem <= 0; m_ec <= 0; m_last <= 1'b1; m_pid <= 1'b0;
        m_rv <= 1'b0; m_rid <= 1'b0; m_a <= '0; m_b <= '0; m_cmd <= '0;
        m_pend <= '0; m_res <= '0; m_err <= '0;
      end else if (m_ph == 0) begin
        if (reqValid[g] != 2'b00) begin
          m_last <= p;
          if (pc >= 4'd1 && pc <= 4'd5) begin
            m_a <= pa; m_b <= pb; m_cmd <= pc; m_pid <= p;
            m_pend <= alu_f(pa, pb, pc);
            m_rem <= S; m_ph <= 1;
          end else begin
            m_rv <= 1'b1; m_rid <= p; m_res <= '0; m_err <= 2'b11; m_ph <= 2;
          end
        end
      end else if (m_ph == 1) begin
        if (m_rem == 1) begin
          m_rv <= 1'b1; m_rid <= m_pid; m_res <= m_pend[31:0]; m_err <= m_pend[33:32];
          m_ph <= 2;
        end else begin
          m_rem <= m_rem - 1;
        end
      end else if (rspReady[g]) begin
        m_rv <= 1'b0; m_cmd <= '0; m_ph <= 0;
        if (m_err != 2'b00 && m_ec < 255) m_ec <= m_ec + 1;
      end
    end

    always @(negedge clk) begin
      #2;
      if (chk_en[g]) begin
        chk($sformatf("m%0d_reqReady", g), reqReady[g], exp_rr(rst_n[g], m_ph, reqValid[g], m_last));
        chk($sformatf("m%0d_aluA", g), aluA[g], m_a);
        chk($sformatf("m%0d_aluB", g), aluB[g], m_b);
        chk($sformatf("m%0d_aluCmd", g), aluCmd[g], m_cmd);
        chk($sformatf("m%0d_rspValid", g), rspValid[g], m_rv);
        chk($sformatf("m%0d_rspId", g), rspId[g], m_rid);
        chk($sformatf("m%0d_rspResult", g), rspResult[g], m_res);
        chk($sformatf("m%0d_rspError", g), rspError[g], m_err);
        chk($sformatf("m%0d_busy", g), busy[g], m_ph != 0);
        chk($sformatf("m%0d_errCount", g), errCount[g], m_ec);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a request, hold it until accepted, then drop valid.
  // Returns at the negedge following the accept edge.
  task automatic issue(input int g, input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] c);
    bit ok;
    reqA[g][w*16 +: 16] = a;
    reqB[g][w*16 +: 16] = b;
    reqCmd[g][w*4 +: 4] = c;
    reqValid[g][w] = 1'b1;
    #1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (reqReady[g][w]) begin ok = 1; break; end
      tick(); #1;
    end
    tick();
    reqValid[g][w] = 1'b0;
    chk("issue_accept", ok, 1'b1);
  endtask

  task automatic wait_rsp(input int g, output int n);
    n = 0;
    while (!rspValid[g] && n < 40) begin tick(); n++; end
    chk("rsp_seen", rspValid[g], 1'b1);
  endtask

  initial begin
    int n;
    rst_n  = 2'b00;
    chk_en = 2'b00;
    for (int i = 0; i < 2; i++) begin
      reqValid[i] = '0; reqA[i] = '0; reqB[i] = '0; reqCmd[i] = '0; rspReady[i] = 1'b0;
    end
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_aluCmd", aluCmd[i], 0);
      chk("rst_rspValid", rspValid[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_errCount", errCount[i], 0);
      chk("rst_reqReady", reqReady[i], 0);
    end
    rst_n  = 2'b11;
    chk_en = 2'b11;

    // 1: single add, SETTLE=1
    issue(0, 0, 16'd249, 16'd69, 4'd1);
    chk("t1_busy", busy[0], 1);
    chk("t1_early", rspValid[0], 0);
    chk("t1_aluA", aluA[0], 249);
    chk("t1_aluCmd", aluCmd[0], 1);
    tick();
    chk("t1_rspValid", rspValid[0], 1);
    chk("t1_rspId", rspId[0], 0);
    chk("t1_rspResult", rspResult[0], 318);
    chk("t1_rspError", rspError[0], 0);
    chk("t1_busy_rsp", busy[0], 1);
    rspReady[0] = 1'b1;
    tick();
    chk("t1_done_valid", rspValid[0], 0);
    chk("t1_done_busy", busy[0], 0);
    chk("t1_done_cmd", aluCmd[0], 0);
    rspReady[0] = 1'b0;

    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;

    // 2: simultaneous requests, round-robin order
    reqA[0] = {16'd249, 16'd249};
    reqB[0] = {16'd69, 16'd69};
    reqCmd[0] = {4'd4, 4'd3};
    reqValid[0] = 2'b11;
    rspReady[0] = 1'b1;
    #1 chk("t2_first_grant", reqReady[0], 2'b01);
    tick();
    reqA[0][15:0] = 16'd10; reqB[0][15:0] = 16'd20; reqCmd[0][3:0] = 4'd1;
    #1 chk("t2_wait_ready", reqReady[0], 2'b00);
    chk("t2_aluCmd", aluCmd[0], 3);
    tick();
    chk("t2_r0_valid", rspValid[0], 1);
    chk("t2_r0_id", rspId[0], 0);
    chk("t2_r0_res", rspResult[0], 17181);
    tick();
    #1 chk("t2_hs_valid", rspValid[0], 0);
    chk("t2_second_grant", reqReady[0], 2'b10);
    tick();
    reqValid[0] = 2'b01;
    tick();
    chk("t2_r1_id", rspId[0], 1);
    chk("t2_r1_res", rspResult[0], 3);
    tick();
    #1 chk("t2_third_grant", reqReady[0], 2'b01);
    tick();
    reqValid[0] = 2'b00;
    tick();
    chk("t2_r2_valid", rspValid[0], 1);
    chk("t2_r2_id", rspId[0], 0);
    chk("t2_r2_res", rspResult[0], 30);
    tick();
    rspReady[0] = 1'b0;
    chk("t2_r2_hs", rspValid[0], 0);

    // 3: mod by zero from req1
    issue(0, 1, 16'd7, 16'd0, 4'd5);
    wait_rsp(0, n);
    chk("t3_latency", n, 1);
    chk("t3_err", rspError[0], 2'b10);
    chk("t3_id", rspId[0], 1);
    chk("t3_errCount_before", errCount[0], 0);
    rspReady[0] = 1'b1;
    tick();
    chk("t3_errCount_after", errCount[0], 1);
    rspReady[0] = 1'b0;

    // 4: illegal command
    issue(0, 0, 16'd5, 16'd6, 4'd9);
    chk("t4_valid", rspValid[0], 1);
    chk("t4_err", rspError[0], 2'b11);
    chk("t4_res", rspResult[0], 0);
    chk("t4_aluCmd", aluCmd[0], 0);
    chk("t4_id", rspId[0], 0);
    tick();
    chk("t4_aluCmd_hold", aluCmd[0], 0);
    chk("t4_valid_hold", rspValid[0], 1);
    rspReady[0] = 1'b1;
    tick();
    chk("t4_errCount", errCount[0], 2);
    chk("t4_hs", rspValid[0], 0);
    rspReady[0] = 1'b0;

    // 5: backpressure with a pending second request
    issue(0, 0, 16'd100, 16'd5, 4'd1);
    reqA[0][31:16] = 16'd5; reqB[0][31:16] = 16'd9; reqCmd[0][7:4] = 4'd2;
    reqValid[0][1] = 1'b1;
    tick();
    chk("t5_valid", rspValid[0], 1);
    chk("t5_res", rspResult[0], 105);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_stall_ready", reqReady[0], 2'b00);
      chk("t5_stall_valid", rspValid[0], 1);
      chk("t5_stall_res", rspResult[0], 105);
      chk("t5_stall_id", rspId[0], 0);
    end
    rspReady[0] = 1'b1;
    tick();
    rspReady[0] = 1'b0;
    #1 chk("t5_after_hs_ready", reqReady[0], 2'b10);
    chk("t5_after_hs_valid", rspValid[0], 0);
    tick();
    reqValid[0][1] = 1'b0;
    wait_rsp(0, n);
    chk("t5_sub_res", rspResult[0], 32'hFFFF_FFFC);
    chk("t5_sub_err", rspError[0], 2'b01);
    chk("t5_sub_id", rspId[0], 1);
    rspReady[0] = 1'b1;
    tick();
    chk("t5_errCount", errCount[0], 3);
    rspReady[0] = 1'b0;

    // 6: SETTLE=4 latency, then reset mid-operation
    issue(1, 0, 16'd249, 16'd69, 4'd1);
    wait_rsp(1, n);
    chk("t6_latency", n, 4);
    chk("t6_res", rspResult[1], 318);
    rspReady[1] = 1'b1;
    tick();
    rspReady[1] = 1'b0;
    issue(1, 0, 16'd249, 16'd69, 4'd3);
    tick();
    rst_n[1] = 1'b0;
    reqValid[1] = 2'b01;
    #1 chk("t6_rst_ready", reqReady[1], 2'b00);
    tick();
    chk("t6_rst_aluA", aluA[1], 0);
    chk("t6_rst_aluB", aluB[1], 0);
    chk("t6_rst_aluCmd", aluCmd[1], 0);
    chk("t6_rst_valid", rspValid[1], 0);
    chk("t6_rst_id", rspId[1], 0);
    chk("t6_rst_res", rspResult[1], 0);
    chk("t6_rst_err", rspError[1], 0);
    chk("t6_rst_errCount", errCount[1], 0);
    chk("t6_rst_busy", busy[1], 0);
    reqValid[1] = 2'b00;
    rst_n[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_no_rsp", rspValid[1], 0);
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
